// File: rtl/rand_range_if.sv
// Request/result bundle between game logic (plus the LCG byte stream) and rand_range.
interface rand_range_if;
    logic       req;
    logic [7:0] limit;
    logic [7:0] rnd;
    logic       busy;
    logic       valid;
    logic [7:0] value;
    logic [7:0] tries;

    modport master (
        output req, limit, rnd,
        input  busy, valid, value, tries
    );

    modport slave (
        input  req, limit, rnd,
        output busy, valid, value, tries
    );
endinterface

// File: rtl/rand_range.sv
// Uniform value in [0, limit-1] from an 8-bit random stream: rejection sampling
// against Th = 256 - (256 mod L), then a bit-serial restoring modulo by L.
module rand_range (
    input  logic         clk,
    input  logic         rst_n,
    rand_range_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, SETUP, SAMPLE, REDUCE, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] l_q, l_d;
    logic [8:0] th_q, th_d;
    logic [7:0] x_q, x_d;
    logic [7:0] rem_q, rem_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] try_q, try_d;
    logic [7:0] value_q, value_d;
    logic [7:0] tries_q, tries_d;

    logic       in_bit;
    logic [8:0] rem_sh;
    logic [7:0] rem_nx;
    logic [7:0] try_inc;
    logic       accept;

    // One restoring-division step shared by SETUP (dividend 256) and REDUCE (dividend X).
    always_comb begin
        in_bit  = (state_q == SETUP) ? (cnt_q == 4'd8) : x_q[7];
        rem_sh  = {rem_q, in_bit};
        rem_nx  = (rem_sh >= {1'b0, l_q}) ? 8'(rem_sh - {1'b0, l_q}) : rem_sh[7:0];
        try_inc = (try_q == 8'hFF) ? try_q : try_q + 8'd1;
        accept  = ({1'b0, bus.rnd} < th_q);
    end

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        th_d    = th_q;
        x_d     = x_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        try_d   = try_q;
        value_d = value_q;
        tries_d = tries_q;

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    l_d   = bus.limit;
                    try_d = '0;
                    rem_d = '0;
                    if (bus.limit == 8'd0) begin
                        th_d    = 9'd256;
                        state_d = SAMPLE;
                    end else begin
                        cnt_d   = 4'd8;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                rem_d = rem_nx;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    th_d    = 9'd256 - {1'b0, rem_nx};
                    rem_d   = '0;
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                x_d   = bus.rnd;
                try_d = try_inc;
                if (accept) begin
                    if (l_q == 8'd0) begin
                        value_d = bus.rnd;
                        tries_d = try_inc;
                        state_d = DONE;
                    end else begin
                        cnt_d   = 4'd7;
                        rem_d   = '0;
                        state_d = REDUCE;
                    end
                end
            end
            REDUCE: begin
                rem_d = rem_nx;
                x_d   = {x_q[6:0], 1'b0};
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    value_d = rem_nx;
                    tries_d = try_q;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            l_q     <= '0;
            th_q    <= '0;
            x_q     <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            try_q   <= '0;
            value_q <= '0;
            tries_q <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            th_q    <= th_d;
            x_q     <= x_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            try_q   <= try_d;
            value_q <= value_d;
            tries_q <= tries_d;
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.valid = (state_q == DONE);
    assign bus.value = value_q;
    assign bus.tries = tries_q;

endmodule

// File: tb/tb_rand_range.sv
// Directed bench for rand_range: latency, rejection, modulo results, busy/req, async reset.
module tb_rand_range;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [7:0] last_val;

    rand_range_if ifc ();

    rand_range dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] seq, input int i);
        logic [31:0] t;
        t = seq >> (8 * (3 - i));
        return t[7:0];
    endfunction

    function automatic logic [7:0] lcg(input logic [7:0] x);
        return 8'(x * 8'd233 + 8'd197);
    endfunction

    // Issue one request; seq holds up to 4 bytes presented on successive SAMPLE cycles.
    task automatic run_op(input logic [7:0] lim, input logic [31:0] seq, input int n,
                          input int exp_lat, input logic [7:0] exp_val,
                          input logic [7:0] exp_tries, input string tag, input bit busy_pulse);
        int fs;
        int idx;
        int got;
        int pulses;
        logic [7:0] gval;
        logic [7:0] gtries;
        fs     = (lim == 8'd0) ? 1 : 10;
        got    = -1;
        pulses = 0;
        gval   = '0;
        gtries = '0;
        ifc.limit = lim;
        ifc.req   = 1'b1;
        for (int k = 0; k <= exp_lat + 3; k++) begin
            idx = k - fs;
            if (idx < 0)       ifc.rnd = 8'hAA;
            else if (idx >= n) ifc.rnd = byte_of(seq, n - 1);
            else               ifc.rnd = byte_of(seq, idx);
            if (busy_pulse && k == 4) ifc.req = 1'b1;
            tick();
            ifc.req = 1'b0;
            if (k == 0) begin
                ifc.limit = ~lim;
                check({tag, "_busy_rise"}, 32'(ifc.busy), 32'd1);
                check({tag, "_value_held"}, 32'(ifc.value), 32'(last_val));
            end
            if (ifc.valid) begin
                pulses++;
                if (got < 0) begin
                    got    = k + 1;
                    gval   = ifc.value;
                    gtries = ifc.tries;
                end
            end
        end
        check({tag, "_latency"}, 32'(got), 32'(exp_lat));
        check({tag, "_value"}, 32'(gval), 32'(exp_val));
        check({tag, "_tries"}, 32'(gtries), 32'(exp_tries));
        check({tag, "_one_pulse"}, 32'(pulses), 32'd1);
        check({tag, "_busy_fall"}, 32'(ifc.busy), 32'd0);
        last_val = exp_val;
    endtask

    initial begin
        logic [7:0] g0, g1, g2, g3;
        int vcount;
        checks    = 0;
        failures  = 0;
        last_val  = 8'd0;
        rst_n     = 1'b0;
        ifc.req   = 1'b0;
        ifc.limit = 8'd0;
        ifc.rnd   = 8'd0;
        tick(); tick(); tick();
        check("rst_busy",  32'(ifc.busy),  32'd0);
        check("rst_valid", 32'(ifc.valid), 32'd0);
        check("rst_value", 32'(ifc.value), 32'd0);
        check("rst_tries", 32'(ifc.tries), 32'd0);
        rst_n = 1'b1;
        tick();

        run_op(8'd10,  {8'd255, 8'd255, 8'd255, 8'd37}, 4, 22, 8'd7,   8'd4, "rej_reduce", 1'b1);
        run_op(8'd0,   {8'd200, 24'd0},                 1, 2,  8'd200, 8'd1, "full_range", 1'b0);
        run_op(8'd128, {8'd201, 24'd0},                 1, 19, 8'd73,  8'd1, "pow2",       1'b0);
        run_op(8'd1,   {8'd250, 24'd0},                 1, 19, 8'd0,   8'd1, "lim1",       1'b0);
        run_op(8'd200, {8'd200, 8'd199, 16'd0},         2, 20, 8'd199, 8'd2, "th200",      1'b0);
        run_op(8'd255, {8'd255, 8'd254, 16'd0},         2, 20, 8'd254, 8'd2, "th255",      1'b0);

        // Generator stream from seed 251: 251 rejected (>= 250), 56 accepted -> 6.
        g0 = 8'd251;
        g1 = lcg(g0);
        g2 = lcg(g1);
        g3 = lcg(g2);
        run_op(8'd10, {g0, g1, g2, g3}, 4, 20, 8'd6, 8'd2, "live", 1'b1);

        // req held high with limit 0: DONE at cycles 2, 5, 8.
        ifc.limit = 8'd0;
        ifc.rnd   = 8'd5;
        ifc.req   = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            check($sformatf("b2b_valid_c%0d", c), 32'(ifc.valid), 32'((c % 3) == 2));
        end
        ifc.req = 1'b0;
        tick(); tick();
        check("b2b_value", 32'(ifc.value), 32'd5);
        check("b2b_tries", 32'(ifc.tries), 32'd1);
        check("b2b_idle",  32'(ifc.busy),  32'd0);

        // Abort in REDUCE (cycle T+14), asynchronously.
        vcount    = 0;
        ifc.limit = 8'd10;
        ifc.req   = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (k < 10)      ifc.rnd = 8'hAA;
            else if (k < 13) ifc.rnd = 8'd255;
            else             ifc.rnd = 8'd37;
            tick();
            ifc.req = 1'b0;
            if (ifc.valid) vcount++;
        end
        check("mid_busy_before", 32'(ifc.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  32'(ifc.busy),  32'd0);
        check("mid_rst_valid", 32'(ifc.valid), 32'd0);
        check("mid_rst_value", 32'(ifc.value), 32'd0);
        check("mid_rst_tries", 32'(ifc.tries), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (ifc.valid) vcount++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (ifc.valid) vcount++;
        end
        check("mid_no_valid", 32'(vcount), 32'd0);
        last_val = 8'd0;
        run_op(8'd10, {8'd255, 8'd255, 8'd255, 8'd37}, 4, 22, 8'd7, 8'd4, "after_rst", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rand_range.md
# rand_range

Consumer-side companion to the free-running 8-bit LCG generator. It reads the generator's byte stream and returns a uniformly distributed value in [0, limit-1] on request, using rejection sampling followed by a sequential modulo reduction. Game logic sits upstream and issues one request at a time; the generator's `num` output feeds `rnd` directly.

## Interface
Parameters:
- none; all widths are fixed at 8 bits.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  request strobe; sampled only in IDLE.
- `limit`  in  8  range size, latched on the request-accept edge; 0 means 256.
- `rnd`  in  8  random byte from the generator; a new value is expected every cycle.
- `busy`  out  1  high whenever the state is not IDLE.
- `valid`  out  1  one-cycle pulse when `value` is new.
- `value`  out  8  result, held until the next `valid`.
- `tries`  out  8  number of `rnd` samples taken for the last result, including the accepted one; saturates at 255.

## Operation
- States: IDLE, SETUP, SAMPLE, REDUCE, DONE.
- **IDLE**
  - If `req`=1: latch `limit` into L and clear the try counter.
  - L=0: go to SAMPLE with threshold 256 (accept all).
  - L≠0: go to SETUP.
- **SETUP** (9 cycles)
  - Restoring division of 9-bit 256 by L, one quotient bit per cycle, to obtain R = 256 mod L.
  - Threshold Th = 256 − R (9-bit), then go to SAMPLE.
  - R=0, i.e. L a power of two or L=1, gives Th=256.
- **SAMPLE**
  - Capture `rnd` into X each cycle; `tries` increments, saturating.
  - If X < Th: accept. For L=0, go to DONE with result X; otherwise go to REDUCE.
  - Else: reject and stay in SAMPLE for the next cycle's `rnd`.
- **REDUCE** (8 cycles)
  - Restoring division X / L, MSB first, with a 9-bit partial remainder.
  - After bit 0, the remainder (< L) is the result. Go to DONE.
- **DONE** (1 cycle)
  - `value` <= result, `valid`=1, `tries` output updated. Return to IDLE.
- Arithmetic:
  - All comparisons are unsigned.
  - Th is 9 bits so that 256 is representable.
  - The quotient is discarded.
- Boundary conditions:
  - `req` while busy: ignored, no queueing.
  - `limit` changes after accept: ignored.
  - L=1: Th=256; REDUCE still runs and yields 0.
  - L=255: R=1, Th=255; only X=255 is rejected.
  - `req` held high continuously: a new request is accepted on the IDLE cycle after DONE, giving back-to-back operation.
- Reset (asserted at any time, including mid-SETUP, SAMPLE or REDUCE):
  - Aborts immediately: state=IDLE, `busy`=0, `valid`=0, `value`=0, `tries`=0, internal registers cleared.
  - No `valid` is produced for the aborted request.

## Timing
- Reset values: `busy`=0, `valid`=0, `value`=0, `tries`=0.
- Request accepted on the rising edge at cycle T (IDLE, `req`=1). `busy`=1 from T+1.
- L≠0, no rejections:
  - SETUP at T+1..T+9, SAMPLE at T+10, REDUCE at T+11..T+18, DONE at T+19.
  - `valid` is high during cycle T+19; latency is 19 cycles.
- L=0, no rejections: SAMPLE at T+1, DONE at T+2.
- Each rejection adds exactly 1 cycle.
- `busy` falls the cycle after DONE.
- `value` and `tries` change only when entering DONE.

## Test plan
- **Reject then reduce:** `limit`=10 (Th=250); `rnd`=255 for the first 3 SAMPLE cycles, then 37 → `valid` at T+22, `value`=7, `tries`=4.
- **Full range:** `limit`=0, `rnd`=200 → `valid` at T+2, `value`=200, `tries`=1.
- **Power of two:** `limit`=128, `rnd`=201 → Th=256, no rejection, `valid` at T+19, `value`=73. Then `limit`=1, `rnd`=250 → `value`=0.
- **Threshold edge:** `limit`=200 (R=56, Th=200); `rnd`=200 rejected, then 199 accepted → `value`=199, `tries`=2. Then `limit`=255: `rnd`=255 rejected, then 254 → `value`=254.
- **Live generator:** connect the generator (seed 251; stream 251, 56, 189, 202…) with `limit`=10 and `req` asserted one cycle before the stream reaches 56 at SAMPLE → `value`=6. Also check that a `req` pulse while busy is ignored.
- **Reset mid-operation:** drop `rst_n` at T+14 (in REDUCE) → `busy`, `valid`, `value` and `tries` go to 0 asynchronously, and no `valid` appears. A fresh request after release behaves like the first scenario.
